fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/control block.
- Owns the program counter and drives the instruction memory address.
- Presents the 9-bit instruction to decode, and consumes decode's jump-enable and 4-bit LUT pointer to select the next PC.
- Holds the 16-entry jump-target LUT, plus the start/done run-control state machine.

Parameters:
- PC_W, 10, program counter width in bits; instruction memory depth is 2**PC_W.
- INSTR_W, 9, instruction width, matching the decode input.
- LUT_DEPTH, 16, jump-target entries, indexed by the 4-bit LUT pointer.
- HALT_INSTR, 9'h1FF, encoding that terminates the program.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a program run from PC 0.
- prog_len  in  PC_W  number of instructions; execution of address prog_len-1 ends the run.
- stall  in  1  freezes PC and state for this cycle.
- pc_jmp_en  in  1  taken-jump indication from decode, same cycle as the instruction.
- lut_pointer  in  4  jump LUT index from decode.
- lut_wr_en  in  1  LUT write strobe.
- lut_wr_addr  in  4  LUT write index.
- lut_wr_data  in  PC_W  LUT write value.
- imem_addr  out  PC_W  instruction memory address; equals PC.
- imem_data  in  INSTR_W  combinational instruction memory read data.
- instr  out  INSTR_W  instruction to decode.
- instr_valid  out  1  high when instr is to be executed this cycle.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- cycle_count  out  16  executed-instruction counter.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE, PC=0, cycle_count=0.
  - All LUT entries=0.
  - done=0, busy=0, instr_valid=0, instr=0.
  - Reset asserted mid-run aborts immediately; no partial PC update survives.
- States: IDLE, RUN, DONE.
- IDLE:
  - start -> RUN with PC=0 and cycle_count=0 on the next edge.
  - Other inputs except LUT writes are ignored.
- RUN:
  - instr = imem_data combinationally.
  - instr_valid = !stall.
- RUN advance rules, for a non-stall cycle, in priority order:
  1. instr==HALT_INSTR -> DONE; PC holds; cycle_count increments; pc_jmp_en ignored.
  2. pc_jmp_en=1 -> PC = lut[lut_pointer], which may be any address, including the current one.
  3. PC==prog_len-1 -> DONE; PC holds.
  4. Otherwise PC = PC+1, modulo 2**PC_W; wrap from all-ones to 0 is legal when prog_len=0.
  - cycle_count increments by 1 each non-stall RUN cycle and saturates at 16'hFFFF.
- Stall in RUN: PC, state and cycle_count hold; pc_jmp_en is ignored.
- Start in RUN: ignored.
- DONE:
  - done=1, instr_valid=0, instr=0.
  - PC and cycle_count hold for readout.
  - start -> RUN, restarting at PC 0 with cycle_count cleared.
- LUT writes:
  - Accepted only in IDLE or DONE; ignored in RUN.
  - A write to entry k takes effect on the next edge.
- Latency: next-PC selection is zero-cycle; decode's jump decision in cycle N sets the PC fetched in cycle N+1.
- Outputs busy and done are registered state decodes. imem_addr is the PC register.

Optional Feature:
- Macro: FETCH_JMP_RELATIVE_EN.
- When defined:
  - LUT entries are two's-complement signed offsets.
  - A taken jump sets PC = PC + sign-extended lut[lut_pointer], modulo 2**PC_W.
  - An offset of 0 is a self-loop.
- When undefined: LUT entries are absolute targets, as in rule 2 above.
- All other behaviour is identical.

Test Plan:
- Setup: prog_len=4, no jumps, straight-line code, start pulse -> PC sequence 0,1,2,3 with instr_valid=1 for each, then done=1 and cycle_count=4; PC holds at 3.
- Jump to address 5:
  - Setup: lut[2]=5 written in IDLE; at PC=1 drive pc_jmp_en=1 with lut_pointer=2.
  - Response: next PC=5 (with FETCH_JMP_RELATIVE_EN, lut[2]=4 at PC=1 gives PC=5).
- Halt: imem_data=9'h1FF at PC=2, prog_len=10 -> DONE next cycle, cycle_count=3, PC=2.
- Stall:
  - Setup: stall high for 3 cycles at PC=1 while pc_jmp_en=1.
  - Response: PC stays 1, instr_valid=0, cycle_count unchanged; then resumes at PC=2.
- LUT write and restart:
  - Setup: lut_wr_en during RUN with lut_wr_addr=0, lut_wr_data=7.
  - Response: lut[0] unchanged (0). In DONE, start restarts at PC 0 with cycle_count=0.
- Mid-run reset: reset_n low at PC=3 for one cycle -> state IDLE, PC=0, all LUT entries 0, done=0, busy=0 immediately (asynchronous).

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the program counter, drives the
//                instruction memory address, presents the fetched instruction
//                to decode and selects the next PC from decode's jump request
//                through a 16-entry jump-target LUT. Contains the
//                IDLE/RUN/DONE run-control state machine.
//  Options     : FETCH_JMP_RELATIVE_EN - when defined, LUT entries are signed
//                PC-relative offsets instead of absolute jump targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                  PC_W       = 10,
    parameter int                  INSTR_W    = 9,
    parameter int                  LUT_DEPTH  = 16,
    parameter logic [INSTR_W-1:0]  HALT_INSTR = 9'h1FF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [PC_W-1:0]     prog_len,
    input  logic                stall,
    input  logic                pc_jmp_en,
    input  logic [3:0]          lut_pointer,
    input  logic                lut_wr_en,
    input  logic [3:0]          lut_wr_addr,
    input  logic [PC_W-1:0]     lut_wr_data,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic                busy,
    output logic                done,
    output logic [15:0]         cycle_count
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [PC_W-1:0] C_PC_ZERO = '0;
    localparam logic [PC_W-1:0] C_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]     C_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [15:0]        r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [PC_W-1:0]    r_lut [LUT_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_run;
    logic               w_halt;
    logic               w_at_last;
    logic               w_lut_wr;
    logic [PC_W-1:0]    w_lut_rd;
    logic [PC_W-1:0]    w_jmp_pc;
    logic [PC_W-1:0]    w_seq_pc;
    logic [15:0]        w_cnt_inc;

    // Decode the current instruction and derive every next-PC candidate.
    always_comb begin
        w_run     = (r_state == ST_RUN);
        w_halt    = (imem_data == HALT_INSTR);
        w_lut_wr  = lut_wr_en && (r_state != ST_RUN);
        w_lut_rd  = r_lut[lut_pointer];
        w_seq_pc  = r_pc + C_PC_ONE;
        // A zero program length means "no length limit": the run only ends on
        // a halt instruction, and the PC may wrap from all-ones back to zero.
        w_at_last = (prog_len != C_PC_ZERO) && (r_pc == (prog_len - C_PC_ONE));
        // The counter saturates rather than wrapping so long runs read as max.
        w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + 16'd1);
`ifdef FETCH_JMP_RELATIVE_EN
        // Offset is two's complement and already PC_W wide, so sign extension
        // to the PC width is the identity; the sum wraps modulo 2**PC_W.
        w_jmp_pc  = r_pc + w_lut_rd;
`else
        w_jmp_pc  = w_lut_rd;
`endif
    end

    // ------------------------------------------------------------------------
    // Jump-target LUT: one register per entry, writable only outside RUN so a
    // running program always sees a stable table.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        // Entry k captures write data when addressed by an accepted write.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_lut[k] <= '0;
            end else if (w_lut_wr && (lut_wr_addr == 4'(k))) begin
                r_lut[k] <= lut_wr_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Run-control FSM with PC, executed-instruction counter and registered
    // busy/done state decodes.
    // ------------------------------------------------------------------------
    // Advance state, PC and counter; reset aborts any run immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_pc    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end

                ST_RUN: begin
                    // A stalled cycle freezes everything, including any jump
                    // decode presents during that cycle.
                    if (!stall) begin
                        r_cnt <= w_cnt_inc;
                        if (w_halt) begin
                            // Halt wins over a jump; the PC stays on the halt.
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (pc_jmp_en) begin
                            // A taken jump may land anywhere, including the
                            // last address or itself, so it outranks the
                            // end-of-program check.
                            r_pc <= w_jmp_pc;
                        end else if (w_at_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc <= w_seq_pc;
                        end
                    end
                end

                ST_DONE: begin
                    // PC and counter hold for readout until the next start.
                    if (start) begin
                        r_state <= ST_RUN;
                        r_pc    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Instruction path is combinational so decode sees the fetch in-cycle.
    always_comb begin
        instr       = w_run ? imem_data : '0;
        instr_valid = w_run && !stall;
    end

    assign imem_addr   = r_pc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cycle_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A vector table covers
//                straight-line runs, jumps, halt, stall and LUT write
//                gating; hand-written sequences cover asynchronous mid-run
//                reset, LUT clearing and PC wrap with an unlimited length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;

`ifdef FETCH_JMP_RELATIVE_EN
    localparam int C_JMP2 = 4;     // PC 1 + 4 = 5
`else
    localparam int C_JMP2 = 5;     // absolute target 5
`endif

    logic               clk;
    logic               reset_n;
    logic               start;
    logic [PC_W-1:0]    prog_len;
    logic               stall;
    logic               pc_jmp_en;
    logic [3:0]         lut_pointer;
    logic               lut_wr_en;
    logic [3:0]         lut_wr_addr;
    logic [PC_W-1:0]    lut_wr_data;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               busy;
    logic               done;
    logic [15:0]        cycle_count;

    // Instruction memory model: address low byte, or a halt at one address.
    logic               halt_en;
    logic [PC_W-1:0]    halt_addr;
    assign imem_data = (halt_en && (imem_addr == halt_addr)) ? 9'h1FF
                                                             : {1'b0, imem_addr[7:0]};

    fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .prog_len    (prog_len),
        .stall       (stall),
        .pc_jmp_en   (pc_jmp_en),
        .lut_pointer (lut_pointer),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    typedef struct {
        logic               start;
        logic               stall;
        logic               jen;
        logic [3:0]         ptr;
        logic               wen;
        logic [3:0]         waddr;
        logic [PC_W-1:0]    wdata;
        logic [PC_W-1:0]    plen;
        logic               halt;
        logic [PC_W-1:0]    e_pc;
        logic               e_valid;
        logic               e_busy;
        logic               e_done;
        logic [15:0]        e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t V(input int st, input int sl, input int j, input int p,
                               input int w, input int wa, input int wd, input int pl,
                               input int h, input int epc, input int ev, input int eb,
                               input int ed, input int ec);
        vec_t v;
        v.start = 1'(st);  v.stall = 1'(sl);  v.jen = 1'(j);  v.ptr = 4'(p);
        v.wen = 1'(w);     v.waddr = 4'(wa);  v.wdata = PC_W'(wd);
        v.plen = PC_W'(pl); v.halt = 1'(h);
        v.e_pc = PC_W'(epc); v.e_valid = 1'(ev); v.e_busy = 1'(eb);
        v.e_done = 1'(ed);   v.e_cnt = 16'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every observable output against the expected machine state.
    task automatic chk_state(input string tag, input logic [PC_W-1:0] epc, input logic ev,
                             input logic eb, input logic ed, input logic [15:0] ec);
        logic [INSTR_W-1:0] e_instr;
        e_instr = '0;
        if (eb) e_instr = (halt_en && (epc == halt_addr)) ? 9'h1FF : {1'b0, epc[7:0]};
        chk({tag, " pc"},    32'(imem_addr),   32'(epc));
        chk({tag, " valid"}, 32'(instr_valid), 32'(ev));
        chk({tag, " busy"},  32'(busy),        32'(eb));
        chk({tag, " done"},  32'(done),        32'(ed));
        chk({tag, " count"}, 32'(cycle_count), 32'(ec));
        chk({tag, " instr"}, 32'(instr),       32'(e_instr));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; pc_jmp_en = 0; lut_pointer = 0;
        lut_wr_en = 0; lut_wr_addr = 0; lut_wr_data = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        prog_len = 4;
        halt_en  = 1'b0;
        halt_addr = 10'd2;
        idle_inputs();

        //     st sl j p  w wa wd      pl h   pc v b d cnt
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  0,0,0,0,0)); // reset state
        vq.push_back(V(0,0,0,0, 1,2,C_JMP2, 4,0,  0,0,0,0,0)); // lut[2] in IDLE
        vq.push_back(V(1,0,0,0, 0,0,0,      4,0,  0,0,0,0,0)); // start
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  0,1,1,0,0));
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  1,1,1,0,1));
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  2,1,1,0,2));
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  3,1,1,0,3)); // last address
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  3,0,0,1,4)); // DONE
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  3,0,0,1,4)); // DONE holds
        vq.push_back(V(1,0,0,0, 0,0,0,      8,0,  3,0,0,1,4)); // restart
        vq.push_back(V(0,0,0,0, 0,0,0,      8,0,  0,1,1,0,0));
        vq.push_back(V(0,0,1,2, 0,0,0,      8,0,  1,1,1,0,1)); // jump via lut[2]
        vq.push_back(V(0,0,0,0, 0,0,0,      8,0,  5,1,1,0,2));
        vq.push_back(V(1,0,0,0, 0,0,0,      8,0,  6,1,1,0,3)); // start in RUN ignored
        vq.push_back(V(0,0,0,0, 0,0,0,      8,0,  7,1,1,0,4));
        vq.push_back(V(0,0,0,0, 0,0,0,      8,0,  7,0,0,1,5));
        vq.push_back(V(1,0,0,0, 0,0,0,     10,1,  7,0,0,1,5)); // halt test
        vq.push_back(V(0,0,0,0, 0,0,0,     10,1,  0,1,1,0,0));
        vq.push_back(V(0,0,0,0, 0,0,0,     10,1,  1,1,1,0,1));
        vq.push_back(V(0,0,1,3, 0,0,0,     10,1,  2,1,1,0,2)); // halt beats jump
        vq.push_back(V(0,0,0,0, 0,0,0,     10,1,  2,0,0,1,3));
        vq.push_back(V(1,0,0,0, 0,0,0,      4,0,  2,0,0,1,3)); // stall test
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  0,1,1,0,0));
        vq.push_back(V(0,1,1,2, 0,0,0,      4,0,  1,0,1,0,1));
        vq.push_back(V(1,1,1,2, 0,0,0,      4,0,  1,0,1,0,1));
        vq.push_back(V(0,1,1,2, 0,0,0,      4,0,  1,0,1,0,1));
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  1,1,1,0,1)); // resume
        vq.push_back(V(0,0,0,0, 1,0,7,      4,0,  2,1,1,0,2)); // write in RUN dropped
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  3,1,1,0,3));
        vq.push_back(V(0,0,0,0, 1,15,9,     4,0,  3,0,0,1,4)); // write in DONE
        vq.push_back(V(1,0,0,0, 0,0,0,      4,0,  3,0,0,1,4)); // restart
        vq.push_back(V(0,0,1,0, 0,0,0,      4,0,  0,1,1,0,0)); // lut[0] still 0
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  0,1,1,0,1));
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  1,1,1,0,2));
        vq.push_back(V(0,0,0,0, 0,0,0,      4,0,  2,1,1,0,3));

        tick();
        tick();
        reset_n = 1'b1;
        tick();

        foreach (vq[i]) begin
            start       = vq[i].start;
            stall       = vq[i].stall;
            pc_jmp_en   = vq[i].jen;
            lut_pointer = vq[i].ptr;
            lut_wr_en   = vq[i].wen;
            lut_wr_addr = vq[i].waddr;
            lut_wr_data = vq[i].wdata;
            prog_len    = vq[i].plen;
            halt_en     = vq[i].halt;
            #1;
            chk_state($sformatf("v%0d", i), vq[i].e_pc, vq[i].e_valid,
                      vq[i].e_busy, vq[i].e_done, vq[i].e_cnt);
            tick();
        end

        // Mid-run asynchronous reset at PC 3, taking effect between edges.
        idle_inputs();
        halt_en = 1'b0;
        #1;
        chk_state("pre_reset", 10'd3, 1'b1, 1'b1, 1'b0, 16'd4);
        reset_n = 1'b0;
        #1;
        chk_state("async_reset", 10'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Every LUT entry must read zero: jumping through entry k stays at 0
        // for both absolute targets and relative offsets.
        prog_len = 0;
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 16; k++) begin
            pc_jmp_en   = 1'b1;
            lut_pointer = 4'(k);
            #1;
            chk_state($sformatf("lut_clr%0d", k), 10'd0, 1'b1, 1'b1, 1'b0, 16'(k));
            tick();
        end

        // Halt at PC 0 to get back to DONE with an unlimited program length.
        pc_jmp_en = 1'b0;
        halt_addr = 10'd0;
        halt_en   = 1'b1;
        tick();
        chk_state("halt_pc0", 10'd0, 1'b0, 1'b0, 1'b1, 16'd17);
        halt_en = 1'b0;

        // lut[1]=1022 lands on 1022 in both modes when jumping from PC 0.
        lut_wr_en = 1; lut_wr_addr = 1; lut_wr_data = 10'd1022;
        tick();
        lut_wr_en = 0;
        start = 1;
        tick();
        start = 0;
        pc_jmp_en = 1; lut_pointer = 1;
        #1;
        chk_state("wrap0", 10'd0, 1'b1, 1'b1, 1'b0, 16'd0);
        tick();
        pc_jmp_en = 0;
        chk_state("wrap1", 10'd1022, 1'b1, 1'b1, 1'b0, 16'd1);
        tick();
        chk_state("wrap2", 10'd1023, 1'b1, 1'b1, 1'b0, 16'd2);
        tick();
        chk_state("wrap3", 10'd0, 1'b1, 1'b1, 1'b0, 16'd3);
        tick();
        chk_state("wrap4", 10'd1, 1'b1, 1'b1, 1'b0, 16'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
